// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide execute unit:
// instruction decode fields and FSM state encoding.
package ex_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_datapath.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply into {hi,lo},
// or a restoring divide step with hi as remainder and lo as quotient/dividend.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    add_sum = {1'b0, hi_i} + {1'b0, (lo_i[0] ? opnd_i : {XLEN{1'b0}})};
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    hi_o    = add_sum[XLEN:1];
    lo_o    = {add_sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      // diff[XLEN] is the borrow: set when the shifted remainder is below the divisor
      hi_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: one op at a time, XLEN+1 cycles to valid_o
// (1 cycle for divide-by-zero / overflow), pipeline held through busy_o.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           inst_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [XLEN-1:0]       reg_wdata_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;

  logic [2:0]            f3;
  logic                  is_m, accept, is_div;
  logic                  neg1, neg2, neg, div_zero, ovf;
  logic [XLEN-1:0]       mag1, mag2, fast_res, res;
  logic [XLEN-1:0]       hi_n, lo_n;
  logic [2*XLEN-1:0]     prod_c;
  logic                  unused_inst;

  assign f3          = inst_i[14:12];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
  assign is_m        = (inst_i[6:0] == OPCODE_OP) && (inst_i[31:25] == FUNCT7_MULDIV);
  assign ready_o     = (state_q == IDLE);
  assign accept      = valid_i & ready_o & ~flush_i & is_m;
  assign busy_o      = accept | ~ready_o;
  assign valid_o     = valid_q;
  assign reg_wdata_o = wdata_q;
  assign reg_waddr_o = waddr_q;
  assign is_div      = f3[2];

  always_comb begin
    neg1     = op1_i[XLEN-1] & (f3 inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM});
    neg2     = op2_i[XLEN-1] & (f3 inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM});
    mag1     = neg1 ? -op1_i : op1_i;
    mag2     = neg2 ? -op2_i : op2_i;
    // Remainder follows the dividend; product and quotient follow the sign mismatch
    neg      = (f3 == FUNCT3_REM) ? neg1 : (neg1 ^ neg2);
    div_zero = is_div && (op2_i == '0);
    ovf      = (f3 == FUNCT3_DIV || f3 == FUNCT3_REM) && (op1_i == MOST_NEG) && (op2_i == '1);
    if (div_zero) fast_res = f3[1] ? op1_i : '1;
    else          fast_res = f3[1] ? '0 : MOST_NEG;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .is_div_i (f3_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  always_comb begin
    prod_c = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    case (f3_q)
      FUNCT3_MUL:                             res = prod_c[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: res = prod_c[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                res = neg_q ? -lo_n : lo_n;
      default:                                res = neg_q ? -hi_n : hi_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    valid_d = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d  = f3;
          rd_d  = reg_waddr_i;
          neg_d = neg;
          if (div_zero || ovf) begin
            state_d = DONE;
            valid_d = 1'b1;
            wdata_d = fast_res;
            waddr_d = reg_waddr_i;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(XLEN-1);
            hi_d    = '0;
            lo_d    = is_div ? mag1 : mag2;
            opnd_d  = is_div ? mag2 : mag1;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hi_d = hi_n;
          lo_d = lo_n;
          if (cnt_q == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
            wdata_d = res;
            waddr_d = rd_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      valid_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      valid_q <= valid_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

endmodule
